sd_recorder: RTL and testbench

Streams 16-bit samples from the sample FIFO onto the SD card as consecutive 512-byte blocks through the SD controller's byte-wise write interface. It is the write-direction counterpart of the SD playback driver, and it uses the same byte order and block addressing, so recorded data plays back unchanged. It sits between the capture FIFO (read side) and the SD controller (write port).

---
 rtl/sd_recorder_if.sv | 25 ++
 rtl/sd_recorder.sv | 180 ++++++++++++++++++
 tb/tb_sd_recorder.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_recorder_if.sv
// SD controller byte-wise write port shared by sd_recorder (master) and the
// SD controller (slave).
interface sd_recorder_if;
    logic        SDwr_available;
    logic        SDwr_req;
    logic        SDwr_start;
    logic [31:0] SDwr_address;
    logic [7:0]  SDwr_data;

    modport master (
        input  SDwr_available,
        input  SDwr_req,
        output SDwr_start,
        output SDwr_address,
        output SDwr_data
    );

    modport slave (
        output SDwr_available,
        output SDwr_req,
        input  SDwr_start,
        input  SDwr_address,
        input  SDwr_data
    );
endinterface

// File: rtl/sd_recorder.sv
// sd_recorder: streams 16-bit FIFO samples to the SD card as 512-byte blocks,
// little-endian byte order, block address {block_cnt, 9'h000}.
// Optional feature macro: SDREC_UNDERRUN_CNT_EN enables the saturating
// underrun counter; when undefined underrun_cnt is tied to zero.
module sd_recorder (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [22:0]   base_block,
    input  logic          fifo_empty,
    input  logic          fifo_prog,
    input  logic [15:0]   fifo_data,
    output logic          fifo_rd,
    sd_recorder_if.master sd,
    output logic          busy,
    output logic          done,
    output logic [22:0]   blocks_written,
    output logic [15:0]   underrun_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, XFER, WAIT_DONE} state_t;

    state_t      state_q, state_d;
    logic [22:0] block_cnt_q, block_cnt_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_q, word_d;
    logic        rd_dly_q, rd_dly_d;
    logic        fifo_rd_q, fifo_rd_d;
    logic        wr_start_q, wr_start_d;
    logic [7:0]  data_q, data_d;
    logic        avail_q, avail_d;
    logic        stop_pending_q, stop_pending_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [22:0] blocks_q, blocks_d;

    // Next-state and output computation for the recording FSM.
    always_comb begin
        state_d        = state_q;
        block_cnt_d    = block_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        rd_dly_d       = fifo_rd_q;
        fifo_rd_d      = 1'b0;
        wr_start_d     = wr_start_q;
        avail_d        = sd.SDwr_available;
        stop_pending_d = stop_pending_q;
        done_d         = 1'b0;
        blocks_d       = blocks_q;

        // FIFO data is valid the cycle after the read strobe.
        if (rd_dly_q)
            word_d = fifo_data;

        // Hold the write request until the controller reports itself busy.
        if (wr_start_q && !sd.SDwr_available)
            wr_start_d = 1'b0;

        if (state_q != IDLE && stop)
            stop_pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start && sd.SDwr_available) begin
                    block_cnt_d    = base_block;
                    blocks_d       = '0;
                    stop_pending_d = 1'b0;
                    state_d        = FILL;
                end
            end
            FILL: begin
                if (fifo_prog || (stop_pending_q && !fifo_empty)) begin
                    wr_start_d = 1'b1;
                    byte_cnt_d = '0;
                    fifo_rd_d  = !fifo_empty;
                    state_d    = XFER;
                end else if (stop_pending_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (sd.SDwr_req) begin
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    if (byte_cnt_q[0] && byte_cnt_q != 9'd511) begin
                        if (!fifo_empty)
                            fifo_rd_d = 1'b1;
                        else
                            word_d = '0;
                    end
                    if (byte_cnt_q == 9'd511)
                        state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!avail_q && sd.SDwr_available) begin
                    block_cnt_d = block_cnt_q + 23'd1;
                    blocks_d    = blocks_q + 23'd1;
                    state_d     = FILL;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        data_d = byte_cnt_d[0] ? word_d[15:8] : word_d[7:0];
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            block_cnt_q    <= '0;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            rd_dly_q       <= 1'b0;
            fifo_rd_q      <= 1'b0;
            wr_start_q     <= 1'b0;
            data_q         <= '0;
            avail_q        <= 1'b0;
            stop_pending_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            blocks_q       <= '0;
        end else begin
            state_q        <= state_d;
            block_cnt_q    <= block_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            rd_dly_q       <= rd_dly_d;
            fifo_rd_q      <= fifo_rd_d;
            wr_start_q     <= wr_start_d;
            data_q         <= data_d;
            avail_q        <= avail_d;
            stop_pending_q <= stop_pending_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            blocks_q       <= blocks_d;
        end
    end

`ifdef SDREC_UNDERRUN_CNT_EN
    logic [15:0] underrun_q, underrun_d;
    logic        underrun_clr, underrun_inc;

    // Count zero-filled words before any stop request, saturating at 0xFFFF.
    always_comb begin
        underrun_clr = (state_q == IDLE) && start && sd.SDwr_available;
        underrun_inc = (state_q == XFER) && sd.SDwr_req && byte_cnt_q[0] &&
                       (byte_cnt_q != 9'd511) && fifo_empty && !stop_pending_q;
        underrun_d   = underrun_q;
        if (underrun_clr)
            underrun_d = '0;
        else if (underrun_inc && underrun_q != '1)
            underrun_d = underrun_q + 16'd1;
    end

    // Underrun counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun_q <= '0;
        else
            underrun_q <= underrun_d;
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = '0;
`endif

    assign fifo_rd         = fifo_rd_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign blocks_written  = blocks_q;
    assign sd.SDwr_start   = wr_start_q;
    assign sd.SDwr_address = {block_cnt_q, 9'h000};
    assign sd.SDwr_data    = data_q;

endmodule

// File: tb/tb_sd_recorder.sv
// Directed self-checking bench for sd_recorder with FIFO and SD controller models.
module tb_sd_recorder;

`ifdef SDREC_UNDERRUN_CNT_EN
    localparam int EXP_UNDER = 156;
`else
    localparam int EXP_UNDER = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [22:0] base_block = '0;
    logic        fifo_empty;
    logic        fifo_prog;
    logic [15:0] fifo_data;
    logic        fifo_rd;
    logic        busy;
    logic        done;
    logic [22:0] blocks_written;
    logic [15:0] underrun_cnt;

    sd_recorder_if sd_bus ();

    sd_recorder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .base_block     (base_block),
        .fifo_empty     (fifo_empty),
        .fifo_prog      (fifo_prog),
        .fifo_data      (fifo_data),
        .fifo_rd        (fifo_rd),
        .sd             (sd_bus),
        .busy           (busy),
        .done           (done),
        .blocks_written (blocks_written),
        .underrun_cnt   (underrun_cnt)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] fifo_q[$];
    logic        prog_ovr = 1'b0;
    int          rd_err = 0;
    logic [7:0]  got[$];
    logic [31:0] addr_q[$];
    int          done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // FIFO model: data appears the cycle after the read strobe.
    initial begin
        logic prev_rd;
        prev_rd    = 1'b0;
        fifo_empty = 1'b1;
        fifo_prog  = 1'b0;
        fifo_data  = '0;
        forever begin
            @(negedge clk);
            if (fifo_rd) begin
                if (fifo_q.size() == 0) rd_err++;
                else fifo_data = fifo_q.pop_front();
                if (prev_rd) rd_err++;
            end
            prev_rd    = fifo_rd;
            fifo_empty = (fifo_q.size() == 0);
            fifo_prog  = prog_ovr || (fifo_q.size() >= 256);
        end
    end

    // SD controller model: accepts a block on SDwr_start, reqs every 4 cycles.
    initial begin
        int gap;
        int nbytes;
        logic active;
        active = 1'b0;
        gap = 0;
        nbytes = 0;
        sd_bus.SDwr_available = 1'b1;
        sd_bus.SDwr_req = 1'b0;
        forever begin
            @(negedge clk);
            sd_bus.SDwr_req = 1'b0;
            if (!rst_n) begin
                sd_bus.SDwr_available = 1'b1;
                active = 1'b0;
            end else if (active) begin
                if (gap != 0) gap--;
                else if (nbytes < 512) begin
                    sd_bus.SDwr_req = 1'b1;
                    got.push_back(sd_bus.SDwr_data);
                    nbytes++;
                    gap = 3;
                end else begin
                    sd_bus.SDwr_available = 1'b1;
                    active = 1'b0;
                end
            end else if (sd_bus.SDwr_available && sd_bus.SDwr_start) begin
                sd_bus.SDwr_available = 1'b0;
                active = 1'b1;
                nbytes = 0;
                gap = 4;
                addr_q.push_back(sd_bus.SDwr_address);
            end
        end
    end

    // Count done pulses.
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
    end

    task automatic wait_bytes(input int target);
        for (int i = 0; i < 20000 && got.size() < target; i++) @(negedge clk);
        check("wait_bytes", 32'(got.size() >= target), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        int b0;
        int a0;
        int bad;
        logic [7:0] e;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        // Reset values
        check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_wr_start", {31'd0, sd_bus.SDwr_start}, 32'd0);
        check("rst_wr_data", {24'd0, sd_bus.SDwr_data}, 32'd0);
        check("rst_wr_addr", sd_bus.SDwr_address, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_blocks", {9'd0, blocks_written}, 32'd0);
        check("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single block
        base_block = 23'h10;
        for (int i = 0; i < 256; i++) fifo_q.push_back(16'h0100 + 16'(i));
        repeat (2) @(negedge clk);
        b0 = got.size();
        a0 = addr_q.size();
        pulse_start();
        check("lat_busy", {31'd0, busy}, 32'd1);
        check("lat_start_lo", {31'd0, sd_bus.SDwr_start}, 32'd0);
        @(negedge clk);
        check("lat_start_hi", {31'd0, sd_bus.SDwr_start}, 32'd1);
        check("lat_prefetch", {31'd0, fifo_rd}, 32'd1);
        wait_bytes(b0 + 512);
        repeat (10) @(negedge clk);
        pulse_stop();
        wait_idle();
        check("t1_addr", addr_q[a0], 32'h0000_2000);
        check("t1_b0", {24'd0, got[b0 + 0]}, 32'h00);
        check("t1_b1", {24'd0, got[b0 + 1]}, 32'h01);
        check("t1_b2", {24'd0, got[b0 + 2]}, 32'h01);
        check("t1_b4", {24'd0, got[b0 + 4]}, 32'h02);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            e = i[0] ? 8'h01 : 8'(i / 2);
            if (got[b0 + i] !== e) bad++;
        end
        check("t1_bytes_bad", bad, 0);
        check("t1_blocks", {9'd0, blocks_written}, 32'd1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_underrun", {16'd0, underrun_cnt}, 32'd0);

        // Partial flush
        base_block = 23'h5;
        for (int i = 0; i < 10; i++) fifo_q.push_back(16'hA000 + 16'(i));
        repeat (2) @(negedge clk);
        b0 = got.size();
        a0 = addr_q.size();
        pulse_start();
        pulse_stop();
        wait_bytes(b0 + 512);
        wait_idle();
        check("t2_addr", addr_q[a0], 32'h0000_0A00);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (i < 20) e = i[0] ? 8'hA0 : 8'(i / 2);
            else e = 8'h00;
            if (got[b0 + i] !== e) bad++;
        end
        check("t2_bytes_bad", bad, 0);
        check("t2_b19", {24'd0, got[b0 + 19]}, 32'hA0);
        check("t2_b20", {24'd0, got[b0 + 20]}, 32'h00);
        check("t2_blocks", {9'd0, blocks_written}, 32'd1);
        check("t2_done_cnt", done_cnt, 2);
        check("t2_underrun", {16'd0, underrun_cnt}, 32'd0);

        // Underrun mid-block
        base_block = 23'h20;
        for (int i = 0; i < 100; i++) fifo_q.push_back(16'h3300 + 16'(i));
        prog_ovr = 1'b1;
        repeat (2) @(negedge clk);
        b0 = got.size();
        pulse_start();
        wait_bytes(b0 + 300);
        prog_ovr = 1'b0;
        wait_bytes(b0 + 512);
        repeat (10) @(negedge clk);
        pulse_stop();
        wait_idle();
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (i < 200) e = i[0] ? 8'h33 : 8'(i / 2);
            else e = 8'h00;
            if (got[b0 + i] !== e) bad++;
        end
        check("t3_bytes_bad", bad, 0);
        check("t3_b199", {24'd0, got[b0 + 199]}, 32'h33);
        check("t3_b200", {24'd0, got[b0 + 200]}, 32'h00);
        check("t3_underrun", {16'd0, underrun_cnt}, EXP_UNDER);
        check("t3_blocks", {9'd0, blocks_written}, 32'd1);

        // Multi-block wrap, with a start pulse while busy
        base_block = 23'h7FFFFF;
        for (int i = 0; i < 512; i++) fifo_q.push_back(16'h5500 + 16'(i));
        repeat (2) @(negedge clk);
        b0 = got.size();
        a0 = addr_q.size();
        pulse_start();
        wait_bytes(b0 + 100);
        base_block = 23'h123;
        pulse_start();
        base_block = 23'h7FFFFF;
        @(negedge clk);
        check("t4_busy_start_addr", sd_bus.SDwr_address, 32'hFFFF_FE00);
        check("t4_busy_start_blocks", {9'd0, blocks_written}, 32'd0);
        wait_bytes(b0 + 1024);
        repeat (10) @(negedge clk);
        pulse_stop();
        wait_idle();
        check("t4_addr0", addr_q[a0], 32'hFFFF_FE00);
        check("t4_addr1", addr_q[a0 + 1], 32'h0000_0000);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            e = i[0] ? (8'h55 + 8'(i / 512)) : 8'(i / 2);
            if (got[b0 + i] !== e) bad++;
        end
        check("t4_bytes_bad", bad, 0);
        check("t4_b513", {24'd0, got[b0 + 513]}, 32'h56);
        check("t4_blocks", {9'd0, blocks_written}, 32'd2);
        check("t4_done_cnt", done_cnt, 4);

        // Reset mid-XFER
        base_block = 23'h40;
        for (int i = 0; i < 256; i++) fifo_q.push_back(16'h7700 + 16'(i));
        repeat (2) @(negedge clk);
        b0 = got.size();
        pulse_start();
        wait_bytes(b0 + 300);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_wr_start", {31'd0, sd_bus.SDwr_start}, 32'd0);
        check("t5_rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_addr", sd_bus.SDwr_address, 32'd0);
        check("t5_rst_data", {24'd0, sd_bus.SDwr_data}, 32'd0);
        fifo_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_idle_after", {31'd0, busy}, 32'd0);
        check("t5_blocks_after", {9'd0, blocks_written}, 32'd0);
        base_block = 23'h1;
        for (int i = 0; i < 256; i++) fifo_q.push_back(16'(i));
        repeat (2) @(negedge clk);
        b0 = got.size();
        a0 = addr_q.size();
        pulse_start();
        check("t5_restart_busy", {31'd0, busy}, 32'd1);
        wait_bytes(b0 + 512);
        repeat (10) @(negedge clk);
        pulse_stop();
        wait_idle();
        check("t5_addr", addr_q[a0], 32'h0000_0200);
        check("t5_b2", {24'd0, got[b0 + 2]}, 32'h01);
        check("t5_blocks", {9'd0, blocks_written}, 32'd1);
        check("t5_done_cnt", done_cnt, 5);

        check("fifo_rd_protocol_errs", rd_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
